ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_pkg.sv | 20 ++
 rtl/ram_arbiter_if.sv | 47 ++++
 rtl/ram_arbiter_rr_pick2.sv | 27 ++
 rtl/ram_arbiter.sv | 143 ++++++++++++++
 tb/tb_ram_arbiter.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared memory-system definitions for the DDR-side line arbiter.
// State encoding, requester ids and default geometry.
package ram_arbiter_pkg;

  localparam int DEF_ADDR_W  = 30;
  localparam int DEF_BLOCK_W = 256;
  localparam int DEF_TIMEOUT = 1023;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic {
    ID_IC = 1'b0,
    ID_DC = 1'b1
  } req_id_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Cache-side and DDR-side signals of the line arbiter.
// slave = arbiter view, master = caches plus DDR controller view.
interface ram_arbiter_if
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int BLOCK_W = DEF_BLOCK_W
) ();

  logic               ic_req;
  logic [ADDR_W-1:0]  ic_addr;
  logic               ic_rdy;
  logic               dc_req;
  logic               dc_write;
  logic [ADDR_W-1:0]  dc_addr;
  logic [BLOCK_W-1:0] dc_wdata;
  logic               dc_rdy;
  logic [BLOCK_W-1:0] rdata;
  logic               ram_en;
  logic               ram_write;
  logic [ADDR_W-1:0]  ram_addr;
  logic [BLOCK_W-1:0] ram_wdata;
  logic               ram_rdy;
  logic [BLOCK_W-1:0] ram_rdata;
  logic               busy;
  logic               err_spurious;
  logic               err_timeout;

  modport slave (
    input  ic_req, ic_addr,
    input  dc_req, dc_write, dc_addr, dc_wdata,
    input  ram_rdy, ram_rdata,
    output ic_rdy, dc_rdy, rdata,
    output ram_en, ram_write, ram_addr, ram_wdata,
    output busy, err_spurious, err_timeout
  );

  modport master (
    output ic_req, ic_addr,
    output dc_req, dc_write, dc_addr, dc_wdata,
    output ram_rdy, ram_rdata,
    input  ic_rdy, dc_rdy, rdata,
    input  ram_en, ram_write, ram_addr, ram_wdata,
    input  busy, err_spurious, err_timeout
  );

endinterface

// File: rtl/ram_arbiter_rr_pick2.sv
// Two-way round-robin pick: on contention the requester
// not served last wins; a lone requester wins outright.
module rr_pick2
  import ram_arbiter_pkg::*;
(
  input  logic    ic_req,
  input  logic    dc_req,
  input  req_id_t last,
  output req_id_t gnt,
  output logic    vld
);

  assign vld = ic_req | dc_req;

  always_comb begin
    gnt = ID_IC;
    unique case (1'b1)
      (ic_req & dc_req):
        gnt = (last == ID_IC) ? ID_DC : ID_IC;
      (dc_req & ~ic_req):
        gnt = ID_DC;
      default:
        gnt = ID_IC;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates I-cache and D-cache line traffic onto one DDR
// port: IDLE -> ISSUE -> DONE, all outputs registered.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int BLOCK_W = DEF_BLOCK_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic          clk,
  input logic          rst,
  ram_arbiter_if.slave bus
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  state_t  state_q, state_n;
  req_id_t owner_q, owner_n;
  req_id_t last_q, last_n;
  req_id_t gnt;
  logic    gnt_vld;

  logic               en_q, en_n;
  logic               wr_q, wr_n;
  logic [ADDR_W-1:0]  addr_q, addr_n;
  logic [BLOCK_W-1:0] wdata_q, wdata_n;
  logic [BLOCK_W-1:0] rdata_q, rdata_n;
  logic               ic_rdy_q, ic_rdy_n;
  logic               dc_rdy_q, dc_rdy_n;
  logic               busy_q, busy_n;
  logic               esp_q, esp_n;
  logic               eto_q, eto_n;
  logic [WD_W-1:0]    wd_q, wd_n;

  rr_pick2 u_pick (
    .ic_req (bus.ic_req),
    .dc_req (bus.dc_req),
    .last   (last_q),
    .gnt    (gnt),
    .vld    (gnt_vld)
  );

  always_comb begin
    state_n  = state_q;
    owner_n  = owner_q;
    last_n   = last_q;
    en_n     = en_q;
    wr_n     = wr_q;
    addr_n   = addr_q;
    wdata_n  = wdata_q;
    rdata_n  = rdata_q;
    ic_rdy_n = 1'b0;
    dc_rdy_n = 1'b0;
    eto_n    = eto_q;
    wd_n     = wd_q;
    esp_n    = esp_q | (bus.ram_rdy & (state_q != ISSUE));
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          state_n = ISSUE;
          owner_n = gnt;
          en_n    = 1'b1;
          wd_n    = '0;
          if (gnt == ID_DC) begin
            wr_n    = bus.dc_write;
            addr_n  = bus.dc_addr;
            wdata_n = bus.dc_wdata;
          end else begin
            wr_n    = 1'b0;
            addr_n  = bus.ic_addr;
            wdata_n = '0;
          end
        end
      end
      ISSUE: begin
        if (bus.ram_rdy) begin
          state_n = DONE;
          en_n    = 1'b0;
          if (!wr_q) rdata_n = bus.ram_rdata;
          if (owner_q == ID_DC) dc_rdy_n = 1'b1;
          else                  ic_rdy_n = 1'b1;
        end else begin
          // saturating watchdog; the command stays on the bus
          if (wd_q != WD_MAX) wd_n = wd_q + 1'b1;
          if (wd_n == WD_MAX) eto_n = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        last_n  = owner_q;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= ID_IC;
      last_q   <= ID_IC;
      en_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ic_rdy_q <= 1'b0;
      dc_rdy_q <= 1'b0;
      busy_q   <= 1'b0;
      esp_q    <= 1'b0;
      eto_q    <= 1'b0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_n;
      owner_q  <= owner_n;
      last_q   <= last_n;
      en_q     <= en_n;
      wr_q     <= wr_n;
      addr_q   <= addr_n;
      wdata_q  <= wdata_n;
      rdata_q  <= rdata_n;
      ic_rdy_q <= ic_rdy_n;
      dc_rdy_q <= dc_rdy_n;
      busy_q   <= busy_n;
      esp_q    <= esp_n;
      eto_q    <= eto_n;
      wd_q     <= wd_n;
    end
  end

  assign bus.ram_en       = en_q;
  assign bus.ram_write    = wr_q;
  assign bus.ram_addr     = addr_q;
  assign bus.ram_wdata    = wdata_q;
  assign bus.rdata        = rdata_q;
  assign bus.ic_rdy       = ic_rdy_q;
  assign bus.dc_rdy       = dc_rdy_q;
  assign bus.busy         = busy_q;
  assign bus.err_spurious = esp_q;
  assign bus.err_timeout  = eto_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: expected grants queued
// at drive time, checked at command issue and at completion.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int AW = 30;
  localparam int BW = 256;
  localparam int TO = 8;

  typedef struct {
    bit          is_dc;
    bit          wr;
    logic [AW-1:0] addr;
    logic [BW-1:0] wdata;
    logic [BW-1:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int n_chk = 0;
  int n_err = 0;
  bit exp_eto = 1'b0;
  logic [BW-1:0] model_rdata = '0;
  exp_t exp_q[$];

  ram_arbiter_if #(.ADDR_W(AW), .BLOCK_W(BW)) bus ();

  ram_arbiter #(
    .ADDR_W  (AW),
    .BLOCK_W (BW),
    .TIMEOUT (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [BW-1:0] got,
                     input logic [BW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] mk_data(input logic [AW-1:0] a);
    if (a == 30'h100) return {32{8'hA5}};
    return {8{{2'b00, a}}};
  endfunction

  function automatic void push_exp(input bit is_dc, input bit wr,
                                   input logic [AW-1:0] a,
                                   input logic [BW-1:0] wd);
    exp_t e;
    if (!wr) model_rdata = mk_data(a);
    e.is_dc = is_dc;
    e.wr    = wr;
    e.addr  = a;
    e.wdata = wd;
    e.rdata = model_rdata;
    exp_q.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic serve(input int dly, input bit drop);
    exp_t e;
    int t;
    t = 0;
    while (bus.ram_en !== 1'b1 && t < 40) begin
      tick();
      t++;
    end
    if (bus.ram_en !== 1'b1) begin
      chk("en_wait", 0, 1);
      return;
    end
    if (exp_q.size() == 0) begin
      chk("sb_empty", 0, 1);
      return;
    end
    e = exp_q.pop_front();
    chk("ram_write", bus.ram_write, e.wr);
    chk("ram_addr", bus.ram_addr, e.addr);
    if (e.wr) chk("ram_wdata", bus.ram_wdata, e.wdata);
    for (int i = 1; i <= dly; i++) begin
      tick();
      chk("en_hold", bus.ram_en, 1);
      if (i >= TO) exp_eto = 1'b1;
      chk("err_to", bus.err_timeout, exp_eto);
    end
    bus.ram_rdy   = 1'b1;
    bus.ram_rdata = mk_data(e.addr);
    tick();
    bus.ram_rdy = 1'b0;
    chk("ic_rdy", bus.ic_rdy, !e.is_dc);
    chk("dc_rdy", bus.dc_rdy, e.is_dc);
    chk("rdata", bus.rdata, e.rdata);
    chk("en_drop", bus.ram_en, 0);
    if (drop) begin
      if (e.is_dc) bus.dc_req = 1'b0;
      else         bus.ic_req = 1'b0;
    end
    tick();
    chk("rdy_pulse", {bus.ic_rdy, bus.dc_rdy}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running exp finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.ic_req    = 1'b0;
    bus.ic_addr   = '0;
    bus.dc_req    = 1'b0;
    bus.dc_write  = 1'b0;
    bus.dc_addr   = '0;
    bus.dc_wdata  = '0;
    bus.ram_rdy   = 1'b0;
    bus.ram_rdata = '0;
    repeat (3) tick();
    chk("rst_en", bus.ram_en, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_cmd", {bus.ram_write, bus.ram_addr}, 0);
    chk("rst_wdata", bus.ram_wdata, 0);
    chk("rst_rdy", {bus.ic_rdy, bus.dc_rdy}, 0);
    chk("rst_err", {bus.err_spurious, bus.err_timeout}, 0);
    rst = 1'b1;
    tick();

    // lone I-cache refill, one-cycle issue latency
    bus.ic_addr = 30'h100;
    bus.ic_req  = 1'b1;
    push_exp(1'b0, 1'b0, 30'h100, '0);
    tick();
    chk("lat_en", bus.ram_en, 1);
    chk("lat_busy", bus.busy, 1);
    serve(5, 1'b1);
    chk("idle_busy", bus.busy, 0);

    // contention: DC writeback wins first, then IC
    bus.dc_addr  = 30'h200;
    bus.dc_write = 1'b1;
    bus.dc_wdata = {8{32'hDEAD_BEEF}};
    bus.ic_addr  = 30'h300;
    bus.dc_req   = 1'b1;
    bus.ic_req   = 1'b1;
    push_exp(1'b1, 1'b1, 30'h200, {8{32'hDEAD_BEEF}});
    push_exp(1'b0, 1'b0, 30'h300, '0);
    serve(2, 1'b1);
    serve(3, 1'b1);

    // both held: strict alternation
    bus.dc_write = 1'b0;
    bus.dc_addr  = 30'h2A0;
    bus.ic_addr  = 30'h1C0;
    bus.dc_req   = 1'b1;
    bus.ic_req   = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) push_exp(1'b1, 1'b0, 30'h2A0, '0);
      else            push_exp(1'b0, 1'b0, 30'h1C0, '0);
    end
    for (int k = 0; k < 6; k++) serve(1 + k, 1'b0);
    bus.dc_req = 1'b0;
    bus.ic_req = 1'b0;
    repeat (2) tick();

    // spurious ram_rdy in IDLE
    chk("pre_spur", bus.err_spurious, 0);
    bus.ram_rdy = 1'b1;
    tick();
    bus.ram_rdy = 1'b0;
    chk("err_spur", bus.err_spurious, 1);
    chk("spur_rdy", {bus.ic_rdy, bus.dc_rdy}, 0);
    chk("spur_busy", bus.busy, 0);
    tick();
    chk("spur_sticky", bus.err_spurious, 1);

    // watchdog: withheld completion still finishes
    bus.dc_write = 1'b1;
    bus.dc_addr  = 30'h3F0;
    bus.dc_wdata = {4{64'h0123_4567_89AB_CDEF}};
    bus.dc_req   = 1'b1;
    push_exp(1'b1, 1'b1, 30'h3F0, {4{64'h0123_4567_89AB_CDEF}});
    serve(19, 1'b1);
    chk("to_sticky", bus.err_timeout, 1);

    // reset mid-ISSUE drops the transaction
    bus.ic_addr = 30'h140;
    bus.ic_req  = 1'b1;
    push_exp(1'b0, 1'b0, 30'h140, '0);
    repeat (3) tick();
    chk("pre_rst_en", bus.ram_en, 1);
    rst = 1'b0;
    #1;
    chk("arst_en", bus.ram_en, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_rdata", bus.rdata, 0);
    chk("arst_cmd", {bus.ram_write, bus.ram_addr}, 0);
    chk("arst_err", {bus.err_spurious, bus.err_timeout}, 0);
    bus.ic_req = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    model_rdata = '0;
    exp_eto     = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    repeat (3) begin
      tick();
      chk("post_rst_rdy", {bus.ic_rdy, bus.dc_rdy, bus.busy}, 0);
    end

    bus.dc_write = 1'b0;
    bus.dc_addr  = 30'h0AB;
    bus.dc_req   = 1'b1;
    push_exp(1'b1, 1'b0, 30'h0AB, '0);
    serve(3, 1'b1);
    chk("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
